// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage (A, priority)
// and a small FIFO fed by multi-cycle units (B), with a starvation guard that forces B through.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        A_Valid,
  input  logic [4:0]  A_Addr,
  input  logic [31:0] A_Data,
  output logic        A_Stall,
  input  logic        B_Valid,
  input  logic [4:0]  B_Addr,
  input  logic [31:0] B_Data,
  output logic        B_Ready,
  output logic [4:0]  WAddr,
  output logic [31:0] WData,
  output logic        RegWrite,
  output logic        B_Pending
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {PRIO_A, FORCE_B} state_t;

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic [CNT_W-1:0] starve_q, starve_d;
  state_t        state_q, state_d;
  logic          regwrite_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;

  logic empty, force_b, grant_a, grant_b, enq;

  // Writes to r0 and the reserved kernel registers are silently dropped.
  function automatic logic is_prot(input logic [4:0] a);
    return (a == 5'd0) || (a == 5'd26) || (a == 5'd27);
  endfunction

  assign empty     = (cnt_q == '0);
  assign B_Ready   = (cnt_q != CW'(DEPTH));
  assign B_Pending = !empty;
  // An empty FIFO in FORCE_B falls back to normal A-priority arbitration.
  assign force_b   = (state_q == FORCE_B) && !empty;
  assign A_Stall   = force_b && A_Valid;
  assign grant_a   = !force_b && A_Valid && !is_prot(A_Addr);
  assign grant_b   = !empty && !grant_a;
  assign enq       = B_Valid && B_Ready && !is_prot(B_Addr);

  assign RegWrite = regwrite_q;
  assign WAddr    = waddr_q;
  assign WData    = wdata_q;

  always_comb begin
    starve_d = '0;
    state_d  = PRIO_A;
    // Count only cycles where B waits because A took the port.
    if (!force_b && !empty && grant_a) starve_d = starve_q + 1'b1;
    if (starve_d == CNT_W'(STARVE_LIMIT)) state_d = FORCE_B;
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      addr_mem_q[wr_q] <= B_Addr;
      data_mem_q[wr_q] <= B_Data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      state_q    <= PRIO_A;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      if (enq)     wr_q <= wr_q + 1'b1;
      if (grant_b) rd_q <= rd_q + 1'b1;
      cnt_q      <= cnt_q + CW'(enq) - CW'(grant_b);
      starve_q   <= starve_d;
      state_q    <= state_d;
      regwrite_q <= grant_a || grant_b;
      if (grant_a) begin
        waddr_q <= A_Addr;
        wdata_q <= A_Data;
      end else if (grant_b) begin
        waddr_q <= addr_mem_q[rd_q];
        wdata_q <= data_mem_q[rd_q];
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        Clk = 0, Rst = 0;
  logic        A_Valid = 0, B_Valid = 0;
  logic [4:0]  A_Addr = 0, B_Addr = 0;
  logic [31:0] A_Data = 0, B_Data = 0;
  logic        A_Stall, B_Ready, RegWrite, B_Pending;
  logic [4:0]  WAddr;
  logic [31:0] WData;

  int checks = 0, failures = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Stall(A_Stall),
    .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
    .WAddr(WAddr), .WData(WData), .RegWrite(RegWrite), .B_Pending(B_Pending));

  always #5 Clk = ~Clk;

  typedef struct {
    bit av; bit [4:0] aa; bit [31:0] ad;
    bit bv; bit [4:0] ba; bit [31:0] bd;
    bit st; bit rdy; bit pnd;
    bit rw; bit [4:0] wa; bit [31:0] wd;
  } vec_t;

  typedef struct { bit [4:0] a; bit [31:0] d; } ent_t;

  function automatic vec_t mk(bit av, bit [4:0] aa, bit [31:0] ad, bit bv, bit [4:0] ba,
                              bit [31:0] bd, bit st, bit rdy, bit pnd, bit rw, bit [4:0] wa,
                              bit [31:0] wd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.st = st; v.rdy = rdy; v.pnd = pnd; v.rw = rw; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit av, input bit [4:0] aa, input bit [31:0] ad,
                       input bit bv, input bit [4:0] ba, input bit [31:0] bd);
    A_Valid = av; A_Addr = aa; A_Data = ad;
    B_Valid = bv; B_Addr = ba; B_Data = bd;
  endtask

  // Called 2 time units after a posedge; leaves time 2 units after the next posedge.
  task automatic apply(input string tag, input vec_t v);
    drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd);
    #1;
    chk({tag, ".A_Stall"}, A_Stall, v.st);
    chk({tag, ".B_Ready"}, B_Ready, v.rdy);
    chk({tag, ".B_Pending"}, B_Pending, v.pnd);
    @(posedge Clk); #1;
    chk({tag, ".RegWrite"}, RegWrite, v.rw);
    if (v.rw) begin
      chk({tag, ".WAddr"}, WAddr, v.wa);
      chk({tag, ".WData"}, WData, v.wd);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    Rst = 1;
    @(posedge Clk); @(posedge Clk); #2;
    Rst = 0;
    @(posedge Clk); #2;
  endtask

  function automatic bit prot(input bit [4:0] a);
    return a == 0 || a == 26 || a == 27;
  endfunction

  vec_t tbl[$];
  ent_t mq[$];

  initial begin
    // ---------------- reset state ----------------
    Rst = 1;
    #3;
    chk("rst.RegWrite", RegWrite, 0);
    chk("rst.B_Ready", B_Ready, 1);
    chk("rst.B_Pending", B_Pending, 0);
    chk("rst.A_Stall", A_Stall, 0);
    chk("rst.WAddr", WAddr, 0);
    chk("rst.WData", WData, 0);
    @(posedge Clk); #2;
    Rst = 0;
    @(posedge Clk); #2;

    // ---------------- vector table ----------------
    tbl.push_back(mk(0,  0, 32'h0,  0,  0, 32'h0,  0,1,0, 0, 0, 32'h0));
    tbl.push_back(mk(1,  8, 32'hAA, 0,  0, 32'h0,  0,1,0, 1, 8, 32'hAA));
    tbl.push_back(mk(1,  0, 32'h55, 0,  0, 32'h0,  0,1,0, 0, 8, 32'hAA));
    tbl.push_back(mk(1, 26, 32'h56, 0,  0, 32'h0,  0,1,0, 0, 8, 32'hAA));
    tbl.push_back(mk(1, 27, 32'h57, 0,  0, 32'h0,  0,1,0, 0, 8, 32'hAA));
    tbl.push_back(mk(0,  0, 32'h0,  1, 27, 32'h99, 0,1,0, 0, 8, 32'hAA));
    tbl.push_back(mk(0,  0, 32'h0,  0,  0, 32'h0,  0,1,0, 0, 8, 32'hAA));
    tbl.push_back(mk(1,  9, 32'h33, 1,  5, 32'h11, 0,1,0, 1, 9, 32'h33));
    tbl.push_back(mk(1, 10, 32'h44, 1,  6, 32'h22, 0,1,1, 1,10, 32'h44));
    tbl.push_back(mk(0,  0, 32'h0,  0,  0, 32'h0,  0,0,1, 1, 5, 32'h11));
    tbl.push_back(mk(0,  0, 32'h0,  0,  0, 32'h0,  0,1,1, 1, 6, 32'h22));
    tbl.push_back(mk(0,  0, 32'h0,  0,  0, 32'h0,  0,1,0, 0, 6, 32'h22));
    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

    // ---------------- starvation: A hammers r9 while one B entry waits ----------------
    apply("starve0", mk(1, 9, 32'h100, 1, 3, 32'h77, 0,1,0, 1, 9, 32'h100));
    for (int i = 1; i <= LIMIT; i++)
      apply($sformatf("starve%0d", i),
            mk(1, 9, 32'h100 + i, 0, 0, 0, 0,1,1, 1, 9, 32'h100 + i));
    apply("starve_force", mk(1, 9, 32'h105, 0, 0, 0, 1,1,1, 1, 3, 32'h77));
    apply("starve_resume", mk(1, 9, 32'h105, 0, 0, 0, 0,1,0, 1, 9, 32'h105));
    apply("starve_idle", mk(0, 0, 0, 0, 0, 0, 0,1,0, 0, 9, 32'h105));

    // ---------------- full FIFO with B_Valid held across a dequeue ----------------
    apply("full0", mk(1, 9, 32'h1, 1, 1, 32'hB1, 0,1,0, 1, 9, 32'h1));
    apply("full1", mk(1, 9, 32'h2, 1, 2, 32'hB2, 0,1,1, 1, 9, 32'h2));
    apply("full2", mk(0, 0, 0,     1, 3, 32'hB3, 0,0,1, 1, 1, 32'hB1));
    apply("full3", mk(0, 0, 0,     1, 3, 32'hB3, 0,1,1, 1, 2, 32'hB2));
    apply("full4", mk(0, 0, 0,     0, 0, 0,      0,1,1, 1, 3, 32'hB3));
    apply("full5", mk(0, 0, 0,     0, 0, 0,      0,1,0, 0, 3, 32'hB3));

    // ---------------- async reset with two entries queued ----------------
    apply("ar0", mk(1, 9, 32'h7, 1, 4, 32'hC4, 0,1,0, 1, 9, 32'h7));
    apply("ar1", mk(1, 9, 32'h8, 1, 5, 32'hC5, 0,1,1, 1, 9, 32'h8));
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("ar.full_before", B_Ready, 0);
    Rst = 1;
    #1;
    chk("ar.RegWrite", RegWrite, 0);
    chk("ar.WAddr", WAddr, 0);
    chk("ar.WData", WData, 0);
    chk("ar.B_Ready", B_Ready, 1);
    chk("ar.B_Pending", B_Pending, 0);
    @(posedge Clk); #3;
    Rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk($sformatf("ar.nowrite%0d", i), RegWrite, 0);
      chk($sformatf("ar.pend%0d", i), B_Pending, 0);
    end

    // ---------------- randomized run vs. queue model ----------------
    do_reset();
    begin
      int  starve = 0;
      bit  forced = 0;
      bit  erw;
      bit [4:0]  ewa = 0;
      bit [31:0] ewd = 0;
      for (int c = 0; c < 2000; c++) begin
        bit av, bv, nonempty, rdy, ga, gb;
        bit [4:0] aa, ba;
        bit [31:0] ad, bd;
        ent_t e;
        av = ($urandom % 4) != 0;
        aa = 5'($urandom % 32);
        ad = $urandom;
        bv = ($urandom % 2) != 0;
        ba = 5'($urandom % 32);
        bd = $urandom;
        drive(av, aa, ad, bv, ba, bd);
        #1;
        nonempty = mq.size() > 0;
        rdy = mq.size() < DEPTH;
        chk("rnd.A_Stall", A_Stall, forced && nonempty && av);
        chk("rnd.B_Ready", B_Ready, rdy);
        chk("rnd.B_Pending", B_Pending, nonempty);
        ga = 0; gb = 0;
        if (forced && nonempty) gb = 1;
        else if (av && !prot(aa)) ga = 1;
        else if (nonempty) gb = 1;
        if (forced && nonempty) starve = 0;
        else if (ga && nonempty) starve = starve + 1;
        else starve = 0;
        forced = (starve == LIMIT);
        if (forced) starve = 0;
        erw = ga || gb;
        if (ga) begin ewa = aa; ewd = ad; end
        else if (gb) begin e = mq.pop_front(); ewa = e.a; ewd = e.d; end
        if (bv && rdy && !prot(ba)) begin e.a = ba; e.d = bd; mq.push_back(e); end
        @(posedge Clk); #1;
        chk("rnd.RegWrite", RegWrite, erw);
        chk("rnd.WAddr", WAddr, ewa);
        chk("rnd.WData", WData, ewd);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout at %0t: got no end expected finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
